radar_sig_gen: RTL and testbench

- Synthesises marine-radar signals for closed-loop bench and field testing of the pulse digitizer:
  - 1-bit and 12-bit trigger pulse trains
  - ACP and ARP azimuth pulses
  - 12-bit synthetic video with a single echo window over a noisy floor
- Outputs are driven through io_rx_b pins and an external DAC, then looped back into the digitizer's trigger, ARP, ACP and video inputs.
- Runs on the 64 MHz master clock; timing settings come from master_control_marine_radar registers.

---
 rtl/radar_sig_gen_pkg.sv | 30 +++
 rtl/radar_sig_gen_pulse_timer.sv | 77 +++++++
 rtl/radar_sig_gen.sv | 164 ++++++++++++++++
 tb/tb_radar_sig_gen.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/radar_sig_gen_pkg.sv
// Shared constants and helpers for the marine-radar signal generator:
// noise LFSR stepping and the saturating video-floor adder.
package radar_sig_gen_pkg;

    localparam int              VID_W     = 12;
    localparam logic [15:0]     LFSR_TAPS = 16'hB400;   // x^16 + x^14 + x^13 + x^11
    localparam logic [VID_W-1:0] VID_MAX  = 12'hFFF;

    function automatic logic [15:0] lfsr_step(input logic [15:0] state);
        logic [15:0] shifted;
        shifted = {1'b0, state[15:1]};
        if (state[0]) begin
            lfsr_step = shifted ^ LFSR_TAPS;
        end else begin
            lfsr_step = shifted;
        end
    endfunction

    function automatic logic [VID_W-1:0] sat_add_noise(input logic [VID_W-1:0] base,
                                                       input logic [3:0]       noise);
        logic [VID_W:0] sum;
        sum = {1'b0, base} + {9'b0_0000_0000, noise};
        if (sum[VID_W]) begin
            sat_add_noise = VID_MAX;
        end else begin
            sat_add_noise = sum[VID_W-1:0];
        end
    endfunction

endpackage

// File: rtl/radar_sig_gen_pulse_timer.sv
// Free-running period counter with settings latched at each period start;
// provides the clipped pulse condition and period start/wrap indications.
module radar_sig_gen_pulse_timer
    import radar_sig_gen_pkg::*;
#(
    parameter int CW = 24
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic [CW-1:0] period,
    input  logic [CW-1:0] width,
    output logic [CW-1:0] cnt,
    output logic          at_zero,
    output logic          valid,
    output logic          start,
    output logic          wrap,
    output logic          pulse
);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] p_l_r;
    logic [CW-1:0] w_l_r;
    logic [CW-1:0] p_eff_s;
    logic [CW-1:0] w_eff_s;
    logic [CW-1:0] p_last_s;
    logic [CW-1:0] lim_s;

    assign cnt = cnt_r;

    // Effective settings: at count zero the port values are used directly.
    always_comb begin
        at_zero  = (cnt_r == {CW{1'b0}});
        p_eff_s  = p_l_r;
        w_eff_s  = w_l_r;
        if (at_zero) begin
            p_eff_s = period;
            w_eff_s = width;
        end else begin
            p_eff_s = p_l_r;
            w_eff_s = w_l_r;
        end
        p_last_s = p_eff_s - {{(CW-1){1'b0}}, 1'b1};
        valid    = enable & (p_eff_s >= CW'(2));
        // Clip the width so every period keeps at least one low tick.
        if (w_eff_s < p_last_s) begin
            lim_s = w_eff_s;
        end else begin
            lim_s = p_last_s;
        end
        pulse = valid & (cnt_r < lim_s);
        start = valid & at_zero;
        wrap  = valid & (cnt_r == p_last_s);
    end

    // Counter and latched period/width.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r <= {CW{1'b0}};
            p_l_r <= {CW{1'b0}};
            w_l_r <= {CW{1'b0}};
        end else if (!enable) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            if (at_zero) begin
                p_l_r <= period;
                w_l_r <= width;
            end
            if (wrap || !valid) begin
                cnt_r <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/radar_sig_gen.sv
// Marine-radar test signal generator: trigger, ACP/ARP azimuth pulses and
// synthetic video with one echo window over an LFSR noise floor.
module radar_sig_gen
    import radar_sig_gen_pkg::*;
#(
    parameter int          CW        = 24,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic [CW-1:0] trig_period,
    input  logic [CW-1:0] trig_width,
    input  logic [11:0]   trig_level,
    input  logic [CW-1:0] acp_period,
    input  logic [CW-1:0] acp_width,
    input  logic [15:0]   acps_per_arp,
    input  logic [CW-1:0] echo_delay,
    input  logic [CW-1:0] echo_len,
    input  logic [11:0]   echo_amp,
    input  logic [11:0]   vid_floor,
    output logic          trig_out,
    output logic [11:0]   trig_analog,
    output logic          trig_strobe,
    output logic          acp_out,
    output logic          arp_out,
    output logic [11:0]   video_out,
    output logic [31:0]   n_trigs_gen
);

    logic [CW-1:0] t_cnt_s;
    logic          t_zero_s;
    logic          t_valid_s;
    logic          t_start_s;
    logic          t_pulse_s;
    logic          t_wrap_unused_s;
    logic [CW-1:0] a_cnt_unused_s;
    logic          a_zero_unused_s;
    logic          a_valid_unused_s;
    logic          a_start_unused_s;
    logic          a_wrap_s;
    logic          a_pulse_s;

    logic [CW-1:0] ed_l_r;
    logic [CW-1:0] el_l_r;
    logic [CW-1:0] ed_eff_s;
    logic [CW-1:0] el_eff_s;
    logic          in_echo_s;
    logic [15:0]   aidx_r;
    logic [15:0]   aidx_next_s;
    logic [16:0]   aidx_inc_s;
    logic [15:0]   lfsr_r;

    radar_sig_gen_pulse_timer #(.CW(CW)) u_trig_timer (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .period  (trig_period),
        .width   (trig_width),
        .cnt     (t_cnt_s),
        .at_zero (t_zero_s),
        .valid   (t_valid_s),
        .start   (t_start_s),
        .wrap    (t_wrap_unused_s),
        .pulse   (t_pulse_s)
    );

    radar_sig_gen_pulse_timer #(.CW(CW)) u_acp_timer (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .period  (acp_period),
        .width   (acp_width),
        .cnt     (a_cnt_unused_s),
        .at_zero (a_zero_unused_s),
        .valid   (a_valid_unused_s),
        .start   (a_start_unused_s),
        .wrap    (a_wrap_s),
        .pulse   (a_pulse_s)
    );

    // Echo window test; the end is computed one bit wider so it never wraps.
    always_comb begin
        ed_eff_s = ed_l_r;
        el_eff_s = el_l_r;
        if (t_zero_s) begin
            ed_eff_s = echo_delay;
            el_eff_s = echo_len;
        end else begin
            ed_eff_s = ed_l_r;
            el_eff_s = el_l_r;
        end
        in_echo_s = t_valid_s
                  & ({1'b0, t_cnt_s} >= {1'b0, ed_eff_s})
                  & ({1'b0, t_cnt_s} <  ({1'b0, ed_eff_s} + {1'b0, el_eff_s}));
    end

    // ACP index; comparing against the live acps_per_arp lets a shrink wrap early.
    always_comb begin
        aidx_inc_s  = {1'b0, aidx_r} + 17'd1;
        aidx_next_s = aidx_r;
        if (!enable) begin
            aidx_next_s = 16'd0;
        end else if (!a_wrap_s) begin
            aidx_next_s = aidx_r;
        end else if (acps_per_arp == 16'd0) begin
            aidx_next_s = 16'd0;
        end else if (aidx_inc_s >= {1'b0, acps_per_arp}) begin
            aidx_next_s = 16'd0;
        end else begin
            aidx_next_s = aidx_inc_s[15:0];
        end
    end

    // Echo settings latch, ACP index and noise LFSR.
    always_ff @(posedge clock) begin
        if (reset) begin
            ed_l_r <= {CW{1'b0}};
            el_l_r <= {CW{1'b0}};
            aidx_r <= 16'd0;
            lfsr_r <= LFSR_SEED;
        end else begin
            if (enable && t_zero_s) begin
                ed_l_r <= echo_delay;
                el_l_r <= echo_len;
            end
            aidx_r <= aidx_next_s;
            if (enable) begin
                lfsr_r <= lfsr_step(lfsr_r);
            end
        end
    end

    // Registered outputs; the trigger count is held while disabled.
    always_ff @(posedge clock) begin
        if (reset) begin
            trig_out    <= 1'b0;
            trig_analog <= 12'd0;
            trig_strobe <= 1'b0;
            acp_out     <= 1'b0;
            arp_out     <= 1'b0;
            video_out   <= 12'd0;
            n_trigs_gen <= 32'd0;
        end else if (!enable) begin
            trig_out    <= 1'b0;
            trig_analog <= 12'd0;
            trig_strobe <= 1'b0;
            acp_out     <= 1'b0;
            arp_out     <= 1'b0;
            video_out   <= 12'd0;
        end else begin
            trig_out    <= t_pulse_s;
            trig_analog <= t_pulse_s ? trig_level : 12'd0;
            trig_strobe <= t_start_s;
            acp_out     <= a_pulse_s;
            arp_out     <= a_pulse_s & (aidx_r == 16'd0) & (acps_per_arp != 16'd0);
            video_out   <= in_echo_s ? echo_amp : sat_add_noise(vid_floor, lfsr_r[3:0]);
            if (t_start_s) begin
                n_trigs_gen <= n_trigs_gen + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_radar_sig_gen.sv
// Self-checking bench for radar_sig_gen: per-cycle reference model plus
// directed scenarios with hand-computed expectations.
module tb_radar_sig_gen;

    localparam int CW = 24;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [CW-1:0] trig_period = '0, trig_width = '0;
    logic [11:0]   trig_level = '0;
    logic [CW-1:0] acp_period = '0, acp_width = '0;
    logic [15:0]   acps_per_arp = '0;
    logic [CW-1:0] echo_delay = '0, echo_len = '0;
    logic [11:0]   echo_amp = '0, vid_floor = '0;
    logic          trig_out, trig_strobe, acp_out, arp_out;
    logic [11:0]   trig_analog, video_out;
    logic [31:0]   n_trigs_gen;

    int checks = 0;
    int failures = 0;

    radar_sig_gen #(.CW(CW), .LFSR_SEED(SEED)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .trig_period(trig_period), .trig_width(trig_width), .trig_level(trig_level),
        .acp_period(acp_period), .acp_width(acp_width), .acps_per_arp(acps_per_arp),
        .echo_delay(echo_delay), .echo_len(echo_len), .echo_amp(echo_amp),
        .vid_floor(vid_floor), .trig_out(trig_out), .trig_analog(trig_analog),
        .trig_strobe(trig_strobe), .acp_out(acp_out), .arp_out(arp_out),
        .video_out(video_out), .n_trigs_gen(n_trigs_gen)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: positions within the trigger/ACP periods
    int          m_tpos, m_tp, m_tw, m_ed, m_el;
    int          m_apos, m_ap, m_aw, m_aidx;
    logic [15:0] m_lfsr;
    logic [31:0] m_n;
    bit          m_ready = 1'b0;
    bit          e_trig, e_strobe, e_acp, e_arp;
    int          e_analog, e_video;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_tpos = 0; m_tp = 0; m_tw = 0; m_ed = 0; m_el = 0;
            m_apos = 0; m_ap = 0; m_aw = 0; m_aidx = 0;
            m_lfsr = SEED; m_n = 0; m_ready = 1'b1;
            e_trig = 0; e_strobe = 0; e_acp = 0; e_arp = 0; e_analog = 0; e_video = 0;
        end else if (!enable) begin
            m_tpos = 0; m_apos = 0; m_aidx = 0;
            e_trig = 0; e_strobe = 0; e_acp = 0; e_arp = 0; e_analog = 0; e_video = 0;
        end else begin
            bit tv, av;
            if (m_tpos == 0) begin
                m_tp = int'(trig_period); m_tw = int'(trig_width);
                m_ed = int'(echo_delay);  m_el = int'(echo_len);
            end
            if (m_apos == 0) begin
                m_ap = int'(acp_period); m_aw = int'(acp_width);
            end
            tv = (m_tp >= 2);
            av = (m_ap >= 2);
            e_trig   = tv && (m_tpos < imin(m_tw, m_tp - 1));
            e_analog = e_trig ? int'(trig_level) : 0;
            e_strobe = tv && (m_tpos == 0);
            if (e_strobe) m_n = m_n + 32'd1;
            if (tv && m_tpos >= m_ed && m_tpos < m_ed + m_el)
                e_video = int'(echo_amp);
            else
                e_video = imin(4095, int'(vid_floor) + int'(m_lfsr % 16));
            e_acp = av && (m_apos < imin(m_aw, m_ap - 1));
            e_arp = e_acp && (m_aidx == 0) && (acps_per_arp != 16'd0);
            if (!tv) m_tpos = 0;
            else if (m_tpos == m_tp - 1) m_tpos = 0;
            else m_tpos = m_tpos + 1;
            if (!av) m_apos = 0;
            else if (m_apos == m_ap - 1) begin
                m_apos = 0;
                if (acps_per_arp == 16'd0 || m_aidx + 1 >= int'(acps_per_arp)) m_aidx = 0;
                else m_aidx = m_aidx + 1;
            end else m_apos = m_apos + 1;
            // Galois form of x^16+x^14+x^13+x^11
            if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
            else m_lfsr = m_lfsr >> 1;
        end
    end

    // Compare DUT against the model just after every active edge
    always @(posedge clock) begin
        #1;
        if (m_ready) begin
            chk("m_trig_out", {31'd0, trig_out}, {31'd0, e_trig});
            chk("m_trig_analog", {20'd0, trig_analog}, e_analog);
            chk("m_trig_strobe", {31'd0, trig_strobe}, {31'd0, e_strobe});
            chk("m_acp_out", {31'd0, acp_out}, {31'd0, e_acp});
            chk("m_arp_out", {31'd0, arp_out}, {31'd0, e_arp});
            chk("m_video_out", {20'd0, video_out}, e_video);
            chk("m_n_trigs", n_trigs_gen, m_n);
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; enable = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic set_all(input int tp, input int tw, input int ap, input int aw,
                           input int apa, input int ed, input int el, input int amp,
                           input int fl);
        trig_period = CW'(tp); trig_width = CW'(tw);
        acp_period = CW'(ap); acp_width = CW'(aw); acps_per_arp = 16'(apa);
        echo_delay = CW'(ed); echo_len = CW'(el); echo_amp = 12'(amp); vid_floor = 12'(fl);
    endtask

    initial begin
        int hi, st, first, cnt_a, cnt_r, cnt_e, bad;
        int strobes[$];
        bit pat[4];
        pat[0] = 1'b1; pat[1] = 1'b1; pat[2] = 1'b1; pat[3] = 1'b0;
        trig_level = 12'h800;

        // Reset state and basic trigger train
        do_reset();
        chk("rst_trig_out", {31'd0, trig_out}, 32'd0);
        chk("rst_n_trigs", n_trigs_gen, 32'd0);
        chk("rst_video", {20'd0, video_out}, 32'd0);
        set_all(100, 5, 0, 0, 0, 0, 0, 0, 0);
        enable = 1'b1;
        hi = 0; st = 0; first = -1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            hi += int'(trig_out);
            if (trig_strobe) begin
                st++;
                if (first < 0) first = i;
            end
            if (i == 4) chk("basic_hi_tick4", {31'd0, trig_out}, 32'd1);
            if (i == 5) chk("basic_lo_tick5", {31'd0, trig_out}, 32'd0);
        end
        chk("basic_strobes", st, 10);
        chk("basic_high_ticks", hi, 50);
        chk("basic_first_strobe", first, 0);
        chk("basic_n_trigs", n_trigs_gen, 32'd10);

        // Width clipping and too-short period
        do_reset();
        set_all(4, 10, 0, 0, 0, 0, 0, 0, 0);
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk("clip_pattern", {31'd0, trig_out}, {31'd0, pat[i % 4]});
        end
        do_reset();
        set_all(1, 10, 0, 0, 0, 0, 0, 0, 0);
        enable = 1'b1;
        hi = 0; st = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            hi += int'(trig_out);
            st += int'(trig_strobe);
        end
        chk("p1_strobes", st, 0);
        chk("p1_high", hi, 0);

        // ARP every 4th ACP, then shrink to 2 mid-cycle
        do_reset();
        set_all(0, 0, 20, 2, 4, 0, 0, 0, 0);
        enable = 1'b1;
        cnt_a = 0; cnt_r = 0;
        for (int i = 0; i < 210; i++) begin
            @(negedge clock);
            if (i < 200) begin
                cnt_a += int'(acp_out);
                cnt_r += int'(arp_out);
            end
            if (i == 80) chk("arp_on_acp4", {31'd0, arp_out}, 32'd1);
            if (i == 20) chk("no_arp_on_acp1", {31'd0, arp_out}, 32'd0);
        end
        chk("acp_high_ticks", cnt_a, 20);
        chk("arp_high_ticks", cnt_r, 6);
        acps_per_arp = 16'd2;
        cnt_r = 0;
        for (int i = 0; i < 90; i++) begin
            @(negedge clock);
            cnt_r += int'(arp_out);
            if (i == 10) chk("arp_on_acp11", {31'd0, arp_out}, 32'd1);
        end
        chk("arp_after_change", cnt_r, 4);

        // Video echo window and saturating floor
        do_reset();
        set_all(1000, 0, 0, 0, 0, 200, 50, 3000, 4090);
        enable = 1'b1;
        cnt_e = 0; first = -1; bad = 0; hi = 0; st = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            hi += int'(trig_out);
            st += int'(trig_strobe);
            if (video_out == 12'd3000) begin
                cnt_e++;
                if (first < 0) first = i;
            end else if (video_out < 12'd4090) begin
                bad++;
            end
        end
        chk("echo_ticks", cnt_e, 50);
        chk("echo_first", first, 200);
        chk("floor_out_of_range", bad, 0);
        chk("w0_no_pulse", hi, 0);
        chk("w0_strobe", st, 1);

        // Period change mid-cycle takes effect at the wrap
        do_reset();
        set_all(100, 5, 0, 0, 0, 0, 0, 0, 0);
        enable = 1'b1;
        for (int i = 0; i < 210; i++) begin
            @(negedge clock);
            if (trig_strobe) strobes.push_back(i);
            if (i == 30) trig_period = CW'(50);
        end
        chk("chg_strobe_count", strobes.size(), 4);
        if (strobes.size() == 4) begin
            chk("chg_s0", strobes[0], 0);
            chk("chg_s1", strobes[1], 100);
            chk("chg_s2", strobes[2], 150);
            chk("chg_s3", strobes[3], 200);
        end

        // Reset mid-pulse, disable hold, re-enable
        do_reset();
        trig_level = 12'h123;
        set_all(100, 5, 20, 5, 1, 0, 0, 0, 100);
        enable = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("mid_pulse_trig", {31'd0, trig_out}, 32'd1);
        chk("mid_pulse_arp", {31'd0, arp_out}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_flags", {28'd0, trig_out, trig_strobe, acp_out, arp_out}, 32'd0);
        chk("rst_mid_analog", {20'd0, trig_analog}, 32'd0);
        chk("rst_mid_video", {20'd0, video_out}, 32'd0);
        chk("rst_mid_n", n_trigs_gen, 32'd0);
        reset = 1'b0;
        repeat (150) @(negedge clock);
        chk("reen_n_before", n_trigs_gen, 32'd2);
        enable = 1'b0;
        @(negedge clock);
        chk("dis_flags", {28'd0, trig_out, trig_strobe, acp_out, arp_out}, 32'd0);
        chk("dis_video", {20'd0, video_out}, 32'd0);
        repeat (5) @(negedge clock);
        chk("dis_n_held", n_trigs_gen, 32'd2);
        enable = 1'b1;
        @(negedge clock);
        chk("reen_strobe", {31'd0, trig_strobe}, 32'd1);
        chk("reen_n", n_trigs_gen, 32'd3);
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
